// File: rtl/ssd_pkg.sv
// Shared types and helpers for the seven-segment scanner.
package ssd_pkg;

  typedef enum logic [0:0] {IDLE, SCAN} state_t;

  localparam int unsigned MAX_DIGITS = 16;

  // One-hot digit enable for idx, optionally inverted for common-anode boards.
  function automatic logic [MAX_DIGITS-1:0] onehot_en(input logic [3:0] idx,
                                                     input logic active_low);
    logic [MAX_DIGITS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return active_low ? ~oh : oh;
  endfunction

endpackage

// File: rtl/ssd_dwell_timer.sv
// Per-digit dwell counter; tc marks the last dwell cycle, tc_next predicts it one cycle early.
module ssd_dwell_timer #(
  parameter int unsigned DWELL_CYCLES = 1
) (
  input  logic clk,
  input  logic n_rst,
  input  logic run,
  output logic tc,
  output logic tc_next
);

  localparam int unsigned CntW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

  logic [CntW-1:0] cnt_q;

  assign tc = run && (cnt_q == CntW'(DWELL_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!n_rst || !run) begin
      cnt_q <= '0;
    end else if (tc) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A fresh or restarted count is terminal next cycle only when every cycle is terminal.
  if (DWELL_CYCLES == 1) begin : g_single
    assign tc_next = 1'b1;
  end else begin : g_multi
    assign tc_next = run && (cnt_q == CntW'(DWELL_CYCLES - 2));
  end

endmodule

// File: rtl/ssd_scanner.sv
// Time-multiplexed seven-segment scanner with tear-free, frame-aligned updates.
// Define SSD_LZ_BLANK_EN to blank leading-zero digits; otherwise digit_blank stays 0.
module ssd_scanner
  import ssd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 8,
  parameter int unsigned DWELL_CYCLES  = 1,
  parameter int unsigned EN_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    stop,
  output logic [3:0]              display_char,
  output logic [NUM_DIGITS-1:0]   ssd_en,
  output logic                    digit_blank,
  output logic                    frame_done,
  output logic                    busy
);

  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned ValW = 4 * NUM_DIGITS;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] EnOff = (EN_ACTIVE_LOW != 0) ? '1 : '0;

  state_t            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [ValW-1:0]   shadow_q, shadow_d;
  logic [ValW-1:0]   pending_q, pending_d;
  logic              pend_valid_q, pend_valid_d;

  logic [3:0]            char_q;
  logic [NUM_DIGITS-1:0] en_q;
  logic                  blank_q, fd_q, busy_q;

  logic                  tc, tc_next;
  logic [MAX_DIGITS-1:0] en_full;
  logic [NUM_DIGITS-1:0] lz_vec;

  ssd_dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell (
    .clk    (clk),
    .n_rst  (n_rst),
    .run    (state_q == SCAN),
    .tc     (tc),
    .tc_next(tc_next)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    pend_valid_d = pend_valid_q;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          shadow_d     = value;
          idx_d        = LastIdx;
          pend_valid_d = 1'b0;
          state_d      = SCAN;
        end
      end
      SCAN: begin
        if (tc) begin
          if (idx_q == '0) begin
            idx_d = LastIdx;
            if (pend_valid_q) begin
              shadow_d     = pending_q;
              pend_valid_d = 1'b0;
            end
            if (stop) state_d = IDLE;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
        // Applied after the frame-end copy so a load on that cycle waits a full frame.
        if (load) begin
          pending_d    = value;
          pend_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SSD_LZ_BLANK_EN
  always_comb begin : lz_scan
    logic zero_run;
    zero_run = 1'b1;
    lz_vec   = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      zero_run  = zero_run && (shadow_d[4*i +: 4] == 4'h0);
      lz_vec[i] = zero_run && (i != 0);
    end
  end
`else
  assign lz_vec = '0;
`endif

  assign en_full = onehot_en(4'(idx_d), EN_ACTIVE_LOW != 0);

  // Outputs are registered from next-state so the first digit appears the cycle after load.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      shadow_q     <= '0;
      pending_q    <= '0;
      pend_valid_q <= 1'b0;
      char_q       <= 4'h0;
      en_q         <= EnOff;
      blank_q      <= 1'b0;
      fd_q         <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      busy_q       <= (state_d == SCAN);
      if (state_d == SCAN) begin
        char_q  <= shadow_d[4*idx_d +: 4];
        en_q    <= en_full[NUM_DIGITS-1:0];
        blank_q <= lz_vec[idx_d];
        fd_q    <= (idx_d == '0) && tc_next;
      end else begin
        char_q  <= 4'h0;
        en_q    <= EnOff;
        blank_q <= 1'b0;
        fd_q    <= 1'b0;
      end
    end
  end

  assign display_char = char_q;
  assign ssd_en       = en_q;
  assign digit_blank  = blank_q;
  assign frame_done   = fd_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_ssd_scanner.sv
// Scoreboard bench for ssd_scanner: three configurations, per-cycle expected outputs queued.
module tb_ssd_scanner;

  typedef struct {
    string       tag;
    logic [15:0] en;
    logic [3:0]  ch;
    logic        fd;
    logic        busy;
    logic        blank;
  } exp_t;

`ifdef SSD_LZ_BLANK_EN
  localparam bit LzOn = 1'b1;
`else
  localparam bit LzOn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_rst;
  logic        load_a, stop_a, fd_a, busy_a, blank_a;
  logic [31:0] value_a;
  logic [3:0]  ch_a;
  logic [7:0]  en_a;
  logic        load_b, stop_b, fd_b, busy_b, blank_b;
  logic [31:0] value_b;
  logic [3:0]  ch_b;
  logic [7:0]  en_b;
  logic        load_c, stop_c, fd_c, busy_c, blank_c;
  logic [3:0]  value_c;
  logic [3:0]  ch_c;
  logic [0:0]  en_c;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t qa[$], qb[$], qc[$];

  ssd_scanner #(.NUM_DIGITS(8), .DWELL_CYCLES(1), .EN_ACTIVE_LOW(0)) u_dut_a (
    .clk(clk), .n_rst(n_rst), .load(load_a), .value(value_a), .stop(stop_a),
    .display_char(ch_a), .ssd_en(en_a), .digit_blank(blank_a), .frame_done(fd_a),
    .busy(busy_a)
  );

  ssd_scanner #(.NUM_DIGITS(8), .DWELL_CYCLES(4), .EN_ACTIVE_LOW(1)) u_dut_b (
    .clk(clk), .n_rst(n_rst), .load(load_b), .value(value_b), .stop(stop_b),
    .display_char(ch_b), .ssd_en(en_b), .digit_blank(blank_b), .frame_done(fd_b),
    .busy(busy_b)
  );

  ssd_scanner #(.NUM_DIGITS(1), .DWELL_CYCLES(2), .EN_ACTIVE_LOW(0)) u_dut_c (
    .clk(clk), .n_rst(n_rst), .load(load_c), .value(value_c), .stop(stop_c),
    .display_char(ch_c), .ssd_en(en_c), .digit_blank(blank_c), .frame_done(fd_c),
    .busy(busy_c)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int sel, input exp_t e);
    case (sel)
      0:       qa.push_back(e);
      1:       qb.push_back(e);
      default: qc.push_back(e);
    endcase
  endtask

  function automatic logic [15:0] dig_mask(input int nd);
    return 16'((32'd1 << nd) - 1);
  endfunction

  task automatic push_idle(input int sel, input int nd, input bit al, input string tag);
    exp_t e;
    e.tag  = tag;
    e.en   = al ? dig_mask(nd) : 16'h0;
    e.ch   = 4'h0;
    e.fd   = 1'b0;
    e.busy = 1'b0;
    e.blank = 1'b0;
    push(sel, e);
  endtask

  // Expected cycles for the first ndig digits (MSB first) of a frame showing v.
  task automatic push_frame(input int sel, input logic [63:0] v, input int nd, input int dw,
                            input bit al, input int ndig, input string tag);
    exp_t e;
    int   i;
    for (int k = 0; k < ndig; k++) begin
      i = nd - 1 - k;
      for (int d = 0; d < dw; d++) begin
        e.tag   = $sformatf("%s[d%0d]", tag, i);
        e.en    = 16'(32'd1 << i);
        if (al) e.en = ~e.en & dig_mask(nd);
        e.ch    = 4'((v >> (4 * i)) & 64'hF);
        e.fd    = (i == 0) && (d == dw - 1);
        e.busy  = 1'b1;
        e.blank = LzOn && (i != 0) && ((v >> (4 * i)) == 64'h0);
        push(sel, e);
      end
    end
  endtask

  task automatic cmp(input string who, input exp_t e, input logic [15:0] en, input logic [3:0] ch,
                     input logic fd, input logic busy, input logic blank);
    check_eq({who, ":", e.tag, ":ssd_en"}, 32'(en), 32'(e.en));
    check_eq({who, ":", e.tag, ":char"}, 32'(ch), 32'(e.ch));
    check_eq({who, ":", e.tag, ":frame_done"}, 32'(fd), 32'(e.fd));
    check_eq({who, ":", e.tag, ":busy"}, 32'(busy), 32'(e.busy));
    check_eq({who, ":", e.tag, ":blank"}, 32'(blank), 32'(e.blank));
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0) cmp("A", qa.pop_front(), 16'(en_a), ch_a, fd_a, busy_a, blank_a);
    if (qb.size() > 0) cmp("B", qb.pop_front(), 16'(en_b), ch_b, fd_b, busy_b, blank_b);
    if (qc.size() > 0) cmp("C", qc.pop_front(), 16'(en_c), ch_c, fd_c, busy_c, blank_c);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while ((qa.size() + qb.size() + qc.size()) != 0 && n < max_cycles) begin
      tick();
      n++;
    end
    check_eq("queues_drained", 32'(qa.size() + qb.size() + qc.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_rst = 1'b0;
    load_a = 1'b0; stop_a = 1'b0; value_a = '0;
    load_b = 1'b0; stop_b = 1'b0; value_b = '0;
    load_c = 1'b0; stop_c = 1'b0; value_c = '0;
    tick();
    push_idle(0, 8, 1'b0, "reset");
    push_idle(1, 8, 1'b1, "reset");
    push_idle(2, 1, 1'b0, "reset");
    tick();
    n_rst = 1'b1;
    tick();

    // Dwell 4 with active-low enables; single-digit scanner with a mid-frame update.
    push_idle(1, 8, 1'b1, "t2_pre");
    push_frame(1, 64'hDEADBEEF, 8, 4, 1'b1, 8, "t2_f1");
    push_frame(1, 64'hDEADBEEF, 8, 4, 1'b1, 8, "t2_f2");
    push_idle(1, 8, 1'b1, "t2_idle");
    push_idle(1, 8, 1'b1, "t2_idle");
    push_idle(2, 1, 1'b0, "n1_pre");
    push_frame(2, 64'h7, 1, 2, 1'b0, 1, "n1_f1");
    push_frame(2, 64'h7, 1, 2, 1'b0, 1, "n1_f2");
    push_frame(2, 64'h3, 1, 2, 1'b0, 1, "n1_f3");
    push_frame(2, 64'h3, 1, 2, 1'b0, 1, "n1_f4");
    for (int k = 0; k < 3; k++) push_idle(2, 1, 1'b0, "n1_idle");
    for (int c = 0; c <= 66; c++) begin
      load_b = (c == 0); value_b = 32'hDEADBEEF; stop_b = (c >= 40);
      load_c = (c == 0 || c == 3); value_c = (c < 3) ? 4'h7 : 4'h3; stop_c = (c >= 8);
      tick();
    end
    load_b = 1'b0; stop_b = 1'b0; load_c = 1'b0; stop_c = 1'b0;
    wait_drain(10);

    // Continuous scan, last-wins pending, load on the frame-end cycle, then stop.
    push_idle(0, 8, 1'b0, "t1_pre");
    push_frame(0, 64'h12345678, 8, 1, 1'b0, 8, "t1_f1");
    push_frame(0, 64'h12345678, 8, 1, 1'b0, 8, "t3_f2");
    push_frame(0, 64'h55555555, 8, 1, 1'b0, 8, "t3_f3");
    push_frame(0, 64'h55555555, 8, 1, 1'b0, 8, "fe_f4");
    push_frame(0, 64'h99999999, 8, 1, 1'b0, 8, "fe_f5");
    push_idle(0, 8, 1'b0, "stop_idle");
    push_idle(0, 8, 1'b0, "stop_idle");
    for (int c = 0; c <= 42; c++) begin
      load_a  = (c == 0 || c == 11 || c == 12 || c == 24);
      value_a = (c == 0) ? 32'h12345678 : (c == 11) ? 32'hAAAAAAAA :
                (c == 12) ? 32'h55555555 : 32'h99999999;
      stop_a  = (c >= 34);
      tick();
    end
    load_a = 1'b0; stop_a = 1'b0;
    wait_drain(10);

    // Single-shot: load and stop together in IDLE.
    push_idle(0, 8, 1'b0, "t4_pre");
    push_frame(0, 64'hCAFEF00D, 8, 1, 1'b0, 8, "t4_f");
    push_idle(0, 8, 1'b0, "t4_idle");
    push_idle(0, 8, 1'b0, "t4_idle");
    for (int c = 0; c <= 10; c++) begin
      load_a = (c == 0); value_a = 32'hCAFEF00D; stop_a = 1'b1;
      tick();
    end
    load_a = 1'b0; stop_a = 1'b0;
    wait_drain(10);

    // Leading-zero blanking patterns.
    push_idle(0, 8, 1'b0, "t6_pre");
    push_frame(0, 64'h000000A0, 8, 1, 1'b0, 8, "t6_a0");
    push_idle(0, 8, 1'b0, "t6_gap");
    push_frame(0, 64'h0, 8, 1, 1'b0, 8, "t6_zero");
    push_idle(0, 8, 1'b0, "t6_idle");
    push_idle(0, 8, 1'b0, "t6_idle");
    for (int c = 0; c <= 19; c++) begin
      load_a = (c == 0 || c == 9); value_a = (c == 0) ? 32'h000000A0 : 32'h0; stop_a = 1'b1;
      tick();
    end
    load_a = 1'b0; stop_a = 1'b0;
    wait_drain(10);

    // Reset at digit index 3 with a pending value; the pending value must never appear.
    push_idle(0, 8, 1'b0, "t5_pre");
    push_frame(0, 64'h11111111, 8, 1, 1'b0, 5, "t5_v1");
    push_idle(0, 8, 1'b0, "t5_rst");
    push_idle(0, 8, 1'b0, "t5_post");
    push_idle(0, 8, 1'b0, "t5_post");
    push_frame(0, 64'h33333333, 8, 1, 1'b0, 8, "t5_f1");
    push_frame(0, 64'h33333333, 8, 1, 1'b0, 8, "t5_f2");
    push_idle(0, 8, 1'b0, "t5_idle");
    for (int c = 0; c <= 25; c++) begin
      load_a  = (c == 0 || c == 2 || c == 8);
      value_a = (c == 0) ? 32'h11111111 : (c == 2) ? 32'h22222222 : 32'h33333333;
      stop_a  = (c >= 18);
      n_rst   = (c != 5);
      tick();
    end
    load_a = 1'b0; stop_a = 1'b0; n_rst = 1'b1;
    wait_drain(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
